dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Data-memory target for the 16-bit CPU's load/store path. Accepts one load/store request at a time over a valid/ready request channel and inserts a programmable number of wait states. Returns read data, or a write acknowledge, over a valid/ready response channel. Replaces the zero-latency DMemory array so the CPU (or a future multi-cycle CPU) exercises a real memory handshake.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 16, request byte-address width
DEPTH, 1024, number of DATA_W words stored
WAIT_CYCLES, 2, wait states between accept and response (0..15)

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept; high only in IDLE
req_write  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  byte address; word index = req_addr>>1
req_wdata  input  DATA_W  store data
rsp_valid  output  1  response available
rsp_ready  input  1  initiator accepts response
rsp_rdata  output  DATA_W  load data; 0 for stores and errors
rsp_err  output  1  misaligned or out-of-range request
busy  output  1  high in WAIT or RESP

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- reset asserted, at any time: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0. Memory contents are not cleared by reset. At time 0 memory is zero-initialised.
- IDLE: req_ready=1. On an edge with req_valid=1:
  - latch write, addr and wdata.
  - load counter=WAIT_CYCLES.
  - go to WAIT.
- WAIT: req_ready=0, busy=1.
  - counter>0: decrement.
  - counter==0: go to RESP at the next edge.
- Commit and capture on the edge entering RESP:
  - err = addr[0] | ((addr>>1) >= DEPTH).
  - Store with !err: mem[addr>>1] <= wdata. rsp_rdata=0.
  - Load with !err: rsp_rdata <= mem[addr>>1]. The read reflects all previously committed stores.
  - err: no memory write, rsp_rdata=0, rsp_err=1.
- Latency: rsp_valid rises WAIT_CYCLES+1 edges after the accept edge. WAIT_CYCLES=0 gives 1 edge.
- RESP: rsp_valid=1, busy=1.
  - rsp_rdata and rsp_err are held stable while rsp_ready=0 (backpressure, unbounded).
  - Edge with rsp_ready=1: go to IDLE; rsp_valid, rsp_err and rsp_rdata clear to 0.
- Minimum spacing between accepts with rsp_ready tied high is WAIT_CYCLES+3 edges.
- req_valid while not in IDLE is ignored (req_ready=0). The initiator holds the request stable until accepted.
- Reset during WAIT aborts the transaction: the pending store is NOT committed and no response is produced.
- Reset during RESP: the store was already committed; the response is dropped.
- No combinational path from req_* to rsp_*. req_ready is a pure function of state.

Test Plan:
1. Store 16'h0005 @addr 0, then load @addr 0 (WAIT_CYCLES=2, rsp_ready=1) -> store: rsp_valid 3 edges after accept, rsp_rdata=0, rsp_err=0. Load: rsp_rdata=5 after 3 edges.
2. Stores 5 @0 and 7 @2, then loads @2 and @0 -> 7 then 5. Repeat with the addresses swapped -> values follow the addresses.
3. Load @addr 1 (misaligned) and @addr 2048 (word 1024 ≥ DEPTH) -> rsp_err=1, rsp_rdata=0. A following load @0 still returns the prior value, so memory is unchanged.
4. Backpressure: load @0 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held stable, req_ready=0. Raise rsp_ready -> IDLE next edge, req_ready=1.
5. Reset in WAIT: store 16'hBEEF @4 accepted, reset asserted one cycle later -> outputs at reset values immediately. A later load @4 returns the old value (0).
6. WAIT_CYCLES=0 instance: load @0 -> rsp_valid 1 edge after accept. Back-to-back requests with rsp_ready=1 are accepted every 3 edges.

Source files
------------

// File: rtl/dmem_if.sv
// dmem_if: load/store request channel and response channel between a CPU-side
// initiator and the data-memory responder.
interface dmem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory target with a programmable
// number of wait states between request accept and response.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready for a request; latches it on req_valid
// ST_WAIT | counting down wait states; commits/captures when count hits 0
// ST_RESP | response presented, held until rsp_ready
module dmem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic  clock,
  input  logic  reset,
  dmem_if.slave bus,
  output logic  busy
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            state_q, state_d;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  // Storage is deliberately outside the reset domain: contents survive reset.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [31:0]       word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              req_err;
  logic              commit;

  assign word_idx = 32'(addr_q[ADDR_W-1:1]);
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign req_err  = addr_q[0] | (word_idx >= 32'(DEPTH));
  assign commit   = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid)    state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == 4'd0)    state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready)    state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt_q   <= 4'(WAIT_CYCLES);
          end
        end
        ST_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            err_q   <= req_err;
            rdata_q <= (!req_err && !write_q) ? mem[mem_idx] : '0;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Reset forces ST_IDLE asynchronously, so an aborted store never commits.
  always_ff @(posedge clock) begin
    if (commit && write_q && !req_err) mem[mem_idx] <= wdata_q;
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != ST_IDLE);
endmodule
